// File: rtl/seq_alu_core_if.sv
// Operand/opcode request channel and result/flag response channel of seq_alu_core.
// Both channels are valid/ready: a transfer happens on a rising edge where valid and ready are both high.
interface seq_alu_core_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_n;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, flag_c, flag_v, flag_z, flag_n
    );
endinterface

// File: rtl/seq_alu_core.sv
// Registered ALU with one operation in flight: single-cycle arithmetic/logic ops and
// iterative one-bit-per-cycle shifts; result and C/V/Z/N flags held until accepted.
module seq_alu_core #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = 3
) (
    input  logic          clock,
    input  logic          clear_n,
    seq_alu_core_if.slave bus,
    output logic [1:0]    state_dbg
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [SHIFT_W-1:0] CNT_ONE = SHIFT_W'(1);

    logic [1:0]         state;
    logic               shr_q;
    logic [WIDTH-1:0]   work;
    logic [SHIFT_W-1:0] cnt;
    logic [WIDTH-1:0]   result_q;
    logic               c_q, v_q, z_q, n_q;

    logic [SHIFT_W-1:0] amt;
    logic               is_shift;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   calc_res;
    logic               calc_c, calc_v;
    logic [WIDTH-1:0]   work_nx;
    logic               shift_c;

    assign amt      = bus.b[SHIFT_W-1:0];
    assign is_shift = (bus.op == OP_SHL) || (bus.op == OP_SHR);

    // Single-cycle datapath, evaluated on the operands presented at the accept edge.
    // The top bit of diff is the unsigned borrow (a < b).
    always_comb begin
        sum      = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        diff     = {1'b0, bus.a} - {1'b0, bus.b};
        calc_res = bus.a;
        calc_c   = 1'b0;
        calc_v   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                calc_res = sum[WIDTH-1:0];
                calc_c   = sum[WIDTH];
                calc_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                calc_res = diff[WIDTH-1:0];
                calc_c   = diff[WIDTH];
                calc_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  calc_res = bus.a & bus.b;
            OP_OR:   calc_res = bus.a | bus.b;
            OP_XOR:  calc_res = bus.a ^ bus.b;
            OP_NOT:  calc_res = ~bus.a;
            default: calc_res = bus.a;
        endcase
    end

    // One logical shift step; the bit leaving the word becomes the carry.
    always_comb begin
        if (shr_q) begin
            work_nx = {1'b0, work[WIDTH-1:1]};
            shift_c = work[0];
        end else begin
            work_nx = {work[WIDTH-2:0], 1'b0};
            shift_c = work[WIDTH-1];
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= ST_IDLE;
            shr_q    <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (is_shift && (amt != '0)) begin
                            shr_q <= (bus.op == OP_SHR);
                            work  <= bus.a;
                            cnt   <= amt;
                            state <= ST_SHIFT;
                        end else begin
                            result_q <= calc_res;
                            c_q      <= calc_c;
                            v_q      <= calc_v;
                            z_q      <= (calc_res == '0);
                            n_q      <= calc_res[WIDTH-1];
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= work_nx;
                    cnt  <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        result_q <= work_nx;
                        c_q      <= shift_c;
                        v_q      <= 1'b0;
                        z_q      <= (work_nx == '0);
                        n_q      <= work_nx[WIDTH-1];
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Leaving DONE never overlaps with a new accept.
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_seq_alu_core.sv
// Directed-vector bench for seq_alu_core (WIDTH=8, SHIFT_W=3).
// Observed word packs {result, c, v, z, n}; expected words are hand-computed.
module tb_seq_alu_core;
    logic       clock;
    logic       clear_n;
    logic [1:0] state_dbg;
    logic [11:0] obs;
    int checks;
    int errors;

    seq_alu_core_if #(.WIDTH(8)) bus();

    seq_alu_core #(.WIDTH(8), .SHIFT_W(3)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    assign obs = {bus.result, bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one request for exactly one edge; returns 1 ns after the accept edge.
    task automatic drive_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // Edges after the accept edge until out_valid rises (bounded); also counts in_ready highs meanwhile.
    task automatic wait_result(output int edges, output int ready_seen);
        edges = 0;
        ready_seen = 0;
        while (!bus.out_valid && edges < 20) begin
            if (bus.in_ready) ready_seen++;
            tick();
            edges++;
        end
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        bus.in_valid = 1'b0; bus.op = 3'b000; bus.a = 8'h00; bus.b = 8'h00; bus.cin = 1'b0;
        bus.out_ready = 1'b0;
        tick(); tick();
        checks++; if (obs !== 12'h000) begin errors++; $display("FAIL reset_result_flags: got %h expected %h", obs, 12'h000); end
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_handshake: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
        clear_n = 1'b1;
        bus.out_ready = 1'b1;
        tick(); tick(); tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_out_ready: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_add();
        int e, r;
        drive_op(3'b000, 8'hFF, 8'h01, 1'b0);
        wait_result(e, r);
        checks++; if (e !== 0) begin errors++; $display("FAIL add_latency: got %0d extra edges expected 0", e); end
        checks++; if (obs !== 12'h00A) begin errors++; $display("FAIL add_ff_01: got %h expected %h", obs, 12'h00A); end
        consume();
        drive_op(3'b000, 8'h7F, 8'h01, 1'b1);
        wait_result(e, r);
        checks++; if (obs !== 12'h815) begin errors++; $display("FAIL add_7f_01_cin: got %h expected %h", obs, 12'h815); end
        consume();
    endtask

    task automatic test_sub();
        int e, r;
        drive_op(3'b001, 8'h01, 8'hAA, 1'b1);
        wait_result(e, r);
        checks++; if (obs !== 12'h578) begin errors++; $display("FAIL sub_01_aa: got %h expected %h", obs, 12'h578); end
        consume();
        drive_op(3'b001, 8'h80, 8'h01, 1'b0);
        wait_result(e, r);
        checks++; if (obs !== 12'h7F4) begin errors++; $display("FAIL sub_80_01: got %h expected %h", obs, 12'h7F4); end
        consume();
    endtask

    task automatic test_logic();
        logic [2:0]  ops [4];
        logic [7:0]  as  [4];
        logic [11:0] exps[4];
        int e, r;
        ops = '{3'b010, 3'b011, 3'b100, 3'b101};
        as  = '{8'hA0, 8'hA0, 8'hA0, 8'h0F};
        exps = '{12'h200, 12'hAC1, 12'h8C1, 12'hF01};
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], as[i], 8'h2C, 1'b1);
            wait_result(e, r);
            checks++; if (e !== 0 || obs !== exps[i]) begin errors++; $display("FAIL logic_op%0d: got %h after %0d edges expected %h after 0", ops[i], obs, e, exps[i]); end
            consume();
        end
    endtask

    task automatic test_shift();
        int e, r;
        drive_op(3'b110, 8'h81, 8'h03, 1'b0);
        // operand changes and a competing request while shifting must not matter
        bus.a = 8'hFF; bus.b = 8'h01; bus.op = 3'b000; bus.in_valid = 1'b1;
        wait_result(e, r);
        bus.in_valid = 1'b0;
        checks++; if (e !== 3) begin errors++; $display("FAIL shl3_latency: got %0d edges expected 3", e); end
        checks++; if (r !== 0) begin errors++; $display("FAIL shl3_in_ready: got %0d cycles ready expected 0", r); end
        checks++; if (obs !== 12'h080) begin errors++; $display("FAIL shl_81_3: got %h expected %h", obs, 12'h080); end
        consume();
        drive_op(3'b111, 8'h81, 8'h01, 1'b0);
        wait_result(e, r);
        checks++; if (e !== 1 || obs !== 12'h408) begin errors++; $display("FAIL shr_81_1: got %h after %0d edges expected %h after 1", obs, e, 12'h408); end
        consume();
        drive_op(3'b110, 8'h5A, 8'h08, 1'b0);
        wait_result(e, r);
        checks++; if (e !== 0 || obs !== 12'h5A0) begin errors++; $display("FAIL shl_by0: got %h after %0d edges expected %h after 0", obs, e, 12'h5A0); end
        consume();
    endtask

    task automatic test_backpressure();
        int e, r;
        drive_op(3'b000, 8'h12, 8'h34, 1'b0);
        wait_result(e, r);
        for (int i = 0; i < 5; i++) begin
            bus.op = 3'b001; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = i[0];
            tick();
            checks++; if (bus.out_valid !== 1'b1 || obs !== 12'h460) begin errors++; $display("FAIL hold_cycle%0d: got valid=%b %h expected valid=1 %h", i, bus.out_valid, obs, 12'h460); end
        end
        // release with a request already waiting: no accept on the release edge
        bus.op = 3'b000; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_edge: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || obs !== 12'h020) begin errors++; $display("FAIL back_to_back: got valid=%b %h expected valid=1 %h", bus.out_valid, obs, 12'h020); end
        consume();
    endtask

    task automatic test_reset_mid_op();
        int e, r, stray;
        drive_op(3'b110, 8'hFF, 8'h07, 1'b0);
        tick(); tick();
        clear_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || obs !== 12'h000) begin errors++; $display("FAIL async_reset: got valid=%b %h expected valid=0 %h", bus.out_valid, obs, 12'h000); end
        #1;
        clear_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (bus.out_valid) stray++;
        end
        checks++; if (stray !== 0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL aborted_op: got %0d valid cycles in_ready=%b expected 0/1", stray, bus.in_ready); end
        drive_op(3'b000, 8'h03, 8'h04, 1'b0);
        wait_result(e, r);
        checks++; if (e !== 0 || obs !== 12'h070) begin errors++; $display("FAIL add_after_reset: got %h after %0d edges expected %h after 0", obs, e, 12'h070); end
        consume();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
